// File: rtl/piso_serializer_pkg.sv
// ============================================================================
// Module  : piso_serializer_pkg
// Brief   : Shared state encoding and counter sizing for the PISO serializer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package piso_serializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int msb);
        return $clog2(msb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_bit_counter.sv
// ============================================================================
// Module  : serializer_bit_counter
// Brief   : Loadable down-counter that saturates at zero.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module serializer_bit_counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module  : piso_serializer
// Brief   : Parallel-in serial-out transmitter with gapless back-to-back words.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int MSB       = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [MSB-1:0] load_data,
    input  logic           load_valid,
    output logic           load_ready,
    output logic           serial_out,
    output logic           serial_valid,
    output logic           done
);

    localparam int            CW     = cnt_width(MSB);
    localparam logic [CW-1:0] c_LAST = CW'(MSB - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic [MSB-1:0] r_shreg;
    logic           w_zero;
    logic           w_accept;
    logic           w_advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        done         = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                w_advance  = en;
                done       = en && w_zero;
                load_ready = done;
                if (done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        w_accept = load_valid && load_ready;
        if (w_accept) begin
            w_state_next = SHIFT;
        end
    end

    // The last-bit edge also shifts, leaving zeros behind so serial_out idles at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
        end else if (w_accept) begin
            r_shreg <= load_data;
        end else if (w_advance) begin
            r_shreg <= MSB_FIRST ? {r_shreg[MSB-2:0], 1'b0} : {1'b0, r_shreg[MSB-1:1]};
        end
    end

    serializer_bit_counter #(
        .WIDTH (CW)
    ) u_bit_counter (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_accept),
        .i_load_value (c_LAST),
        .i_dec        (w_advance),
        .o_zero       (w_zero)
    );

    assign serial_out   = MSB_FIRST ? r_shreg[MSB-1] : r_shreg[0];
    assign serial_valid = (r_state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// Module  : tb_piso_serializer
// Brief   : Bit-queue reference model bench for an 8-bit MSB-first and a 32-bit LSB-first serializer.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en8 = 1'b1, en32 = 1'b1;
    logic [7:0]  ld8 = '0;
    logic [31:0] ld32 = '0;
    logic        lv8 = 1'b0, lv32 = 1'b0;
    logic        rdy8, so8, sv8, dn8;
    logic        rdy32, so32, sv32, dn32;

    int n_cmp = 0;
    int n_err = 0;

    // Model: each DUT is a queue of bits still to be shown, head = current bit.
    logic q8[$];
    logic q32[$];
    logic log8[$];
    logic log32[$];
    int   vcnt8, vcnt32, dcnt8, dcnt32, rcnt8, dat8, dat32;
    logic ev8, eo8, ed8, er8, ev32, eo32, ed32, er32;

    always #5 clk = ~clk;

    piso_serializer #(.MSB(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .load_data(ld8), .load_valid(lv8),
        .load_ready(rdy8), .serial_out(so8), .serial_valid(sv8), .done(dn8)
    );

    piso_serializer #(.MSB(32), .MSB_FIRST(1'b0)) dut32 (
        .clk(clk), .reset(reset), .en(en32), .load_data(ld32), .load_valid(lv32),
        .load_ready(rdy32), .serial_out(so32), .serial_valid(sv32), .done(dn32)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        log8.delete();
        log32.delete();
        vcnt8 = 0; vcnt32 = 0; dcnt8 = 0; dcnt32 = 0; rcnt8 = 0; dat8 = 0; dat32 = 0;
    endtask

    function automatic logic [31:0] pack8();
        logic [31:0] v = '0;
        foreach (log8[i]) v = {v[30:0], log8[i]};
        return v;
    endfunction

    function automatic logic [31:0] pack32();
        logic [31:0] v = '0;
        foreach (log32[i]) v = {v[30:0], log32[i]};
        return v;
    endfunction

    always begin
        @(negedge clk);
        if (reset) begin
            q8.delete();
            q32.delete();
        end
        ev8  = (q8.size() != 0);
        eo8  = ev8 ? q8[0] : 1'b0;
        ed8  = ev8 && (q8.size() == 1) && en8;
        er8  = !ev8 || ed8;
        ev32 = (q32.size() != 0);
        eo32 = ev32 ? q32[0] : 1'b0;
        ed32 = ev32 && (q32.size() == 1) && en32;
        er32 = !ev32 || ed32;
        chk("valid8", 32'(sv8), 32'(ev8));
        chk("out8", 32'(so8), 32'(eo8));
        chk("done8", 32'(dn8), 32'(ed8));
        chk("ready8", 32'(rdy8), 32'(er8));
        chk("valid32", 32'(sv32), 32'(ev32));
        chk("out32", 32'(so32), 32'(eo32));
        chk("done32", 32'(dn32), 32'(ed32));
        chk("ready32", 32'(rdy32), 32'(er32));
        if (sv8) vcnt8++;
        if (sv8 && en8) log8.push_back(so8);
        if (rdy8) rcnt8++;
        if (dn8) begin dcnt8++; dat8 = vcnt8; end
        if (sv32) vcnt32++;
        if (sv32 && en32) log32.push_back(so32);
        if (dn32) begin dcnt32++; dat32 = vcnt32; end
        @(posedge clk);
        if (reset) begin
            q8.delete();
            q32.delete();
        end else begin
            if (ev8 && en8) q8.delete(0);
            if (lv8 && er8) for (int i = 0; i < 8; i++) q8.push_back(ld8[7-i]);
            if (ev32 && en32) q32.delete(0);
            if (lv32 && er32) for (int i = 0; i < 32; i++) q32.push_back(ld32[i]);
        end
    end

    initial begin
        clear_logs();
        // Reset held for two edges
        step(2);
        @(negedge clk);
        chk("t1_valid", 32'(sv8), 32'd0);
        chk("t1_out", 32'(so8), 32'd0);
        chk("t1_done", 32'(dn8), 32'd0);
        chk("t1_ready", 32'(rdy8), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1);

        // Single word 0xA5, MSB first
        clear_logs();
        ld8 = 8'hA5; lv8 = 1'b1;
        step(1);
        lv8 = 1'b0;
        step(10);
        chk("t2_bits", pack8(), 32'hA5);
        chk("t2_nbits", 32'(log8.size()), 32'd8);
        chk("t2_vcycles", 32'(vcnt8), 32'd8);
        chk("t2_dones", 32'(dcnt8), 32'd1);
        chk("t2_done_at", 32'(dat8), 32'd8);

        // Back-to-back 0xA5 then 0x3C
        clear_logs();
        ld8 = 8'hA5; lv8 = 1'b1;
        step(1);
        ld8 = 8'h3C;
        step(8);
        lv8 = 1'b0;
        step(8);
        chk("t3_ready_cycles", 32'(rcnt8), 32'd3);
        step(3);
        chk("t3_bits", pack8(), 32'hA53C);
        chk("t3_nbits", 32'(log8.size()), 32'd16);
        chk("t3_vcycles", 32'(vcnt8), 32'd16);
        chk("t3_dones", 32'(dcnt8), 32'd2);

        // 0xF0 with a 3-cycle stall after the second bit
        clear_logs();
        ld8 = 8'hF0; lv8 = 1'b1;
        step(1);
        lv8 = 1'b0;
        step(1);
        en8 = 1'b0;
        step(3);
        en8 = 1'b1;
        step(12);
        chk("t4_bits", pack8(), 32'hF0);
        chk("t4_vcycles", 32'(vcnt8), 32'd11);
        chk("t4_dones", 32'(dcnt8), 32'd1);
        chk("t4_done_at", 32'(dat8), 32'd11);

        // 0xFF aborted by an asynchronous reset between edges
        clear_logs();
        ld8 = 8'hFF; lv8 = 1'b1;
        step(1);
        lv8 = 1'b0;
        step(4);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t5_valid", 32'(sv8), 32'd0);
        chk("t5_out", 32'(so8), 32'd0);
        chk("t5_ready", 32'(rdy8), 32'd1);
        chk("t5_done", 32'(dn8), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5_no_done", 32'(dcnt8), 32'd0);
        clear_logs();
        ld8 = 8'h81; lv8 = 1'b1;
        step(1);
        lv8 = 1'b0;
        step(10);
        chk("t5_bits", pack8(), 32'h81);
        chk("t5_nbits", 32'(log8.size()), 32'd8);

        // 32-bit LSB first
        clear_logs();
        ld32 = 32'h8000_0001; lv32 = 1'b1;
        step(1);
        lv32 = 1'b0;
        step(34);
        chk("t6_bits", pack32(), 32'h8000_0001);
        chk("t6_nbits", 32'(log32.size()), 32'd32);
        chk("t6_done_at", 32'(dat32), 32'd32);
        chk("t6_dones", 32'(dcnt32), 32'd1);

        // Load in IDLE with en low: accepted, first bit held
        clear_logs();
        ld32 = 32'hDEAD_BEEF; lv32 = 1'b1; en32 = 1'b0;
        step(1);
        lv32 = 1'b0;
        step(4);
        @(negedge clk);
        chk("t6_held_valid", 32'(sv32), 32'd1);
        chk("t6_held_bit", 32'(so32), 32'd1);
        @(posedge clk); #1;
        en32 = 1'b1;
        step(35);
        chk("t6_rev_bits", pack32(), 32'hF77D_B57B);
        chk("t6_rev_nbits", 32'(log32.size()), 32'd32);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            en8   = ($urandom % 4) != 0;
            en32  = ($urandom % 4) != 0;
            lv8   = ($urandom % 3) == 0;
            lv32  = ($urandom % 3) == 0;
            ld8   = 8'($urandom);
            ld32  = $urandom;
            reset = ($urandom % 400) == 0;
            step(1);
        end
        reset = 1'b0; lv8 = 1'b0; lv32 = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
